// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle RV32I-subset sequencing controller.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_I    = 2'd1,
    IMM_S    = 2'd2,
    IMM_B    = 2'd3
  } imm_type_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SRA = 4'd7,
    ALU_SLT = 4'd8
  } alu_op_t;

  localparam int DEFAULT_MEM_TIMEOUT = 16;

  function automatic imm_type_t imm_type_of(input logic [6:0] opcode);
    case (opcode)
      OP_I, OP_LOAD: return IMM_I;
      OP_STORE:      return IMM_S;
      OP_BRANCH:     return IMM_B;
      default:       return IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle; master is the controller side.
interface multicycle_ctrl_if;
  import ctrl_pkg::*;

  logic        start_i;
  logic [31:0] instr_i;
  logic        zero_i;
  logic        mem_ack_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic        addr_sel_o;
  logic        ir_we_o;
  logic        pc_we_o;
  logic        pc_sel_o;
  imm_type_t   imm_type_o;
  logic        alu_src_o;
  alu_op_t     alu_op_o;
  logic        reg_we_o;
  logic        wb_sel_o;
  logic        busy_o;
  logic        instret_o;
  logic        illegal_o;
  logic        timeout_o;

  modport master (
    input  start_i, instr_i, zero_i, mem_ack_i,
    output mem_req_o, mem_we_o, addr_sel_o, ir_we_o, pc_we_o, pc_sel_o,
           imm_type_o, alu_src_o, alu_op_o, reg_we_o, wb_sel_o,
           busy_o, instret_o, illegal_o, timeout_o
  );

  modport slave (
    output start_i, instr_i, zero_i, mem_ack_i,
    input  mem_req_o, mem_we_o, addr_sel_o, ir_we_o, pc_we_o, pc_sel_o,
           imm_type_o, alu_src_o, alu_op_o, reg_we_o, wb_sel_o,
           busy_o, instret_o, illegal_o, timeout_o
  );

endinterface

// File: rtl/multicycle_ctrl_alu_op_dec.sv
// Combinational opcode/funct3/funct7[5] -> ALU operation decode, with an illegal-instruction flag.
module Alu_Op_Dec
  import ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  output alu_op_t    o_alu_op,
  output logic       o_illegal
);

  always_comb begin
    o_alu_op  = ALU_ADD;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_R, OP_I: begin
        case (i_funct3)
          3'b000:  o_alu_op = (i_opcode == OP_R && i_funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  o_alu_op = ALU_SLL;
          3'b010:  o_alu_op = ALU_SLT;
          3'b100:  o_alu_op = ALU_XOR;
          3'b101:  o_alu_op = i_funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  o_alu_op = ALU_OR;
          3'b111:  o_alu_op = ALU_AND;
          default: o_illegal = 1'b1;  // unsigned compare is not in the subset
        endcase
      end
      OP_LOAD, OP_STORE: o_alu_op = ALU_ADD;
      OP_BRANCH: begin
        o_alu_op  = ALU_SUB;
        o_illegal = (i_funct3[2:1] != 2'b00);  // only beq/bne
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I-subset sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared memory port,
// with a per-request wait timeout and sticky halt flags.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  multicycle_ctrl_if.master bus
);

  localparam int            CW        = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_wait, w_wait_next;
  logic          r_illegal, w_illegal_next;
  logic          r_timeout, w_timeout_next;
  logic          w_wait_tick;

  logic [6:0]    w_opcode;
  logic [2:0]    w_funct3;
  logic          w_funct7_5;
  logic          w_unused_instr;
  alu_op_t       w_dec_alu_op;
  logic          w_dec_illegal;

  logic          w_mem_req, w_mem_we, w_addr_sel, w_ir_we, w_pc_we, w_pc_sel;
  logic          w_alu_src, w_reg_we, w_wb_sel, w_instret;
  imm_type_t     w_imm_type;
  alu_op_t       w_alu_op;

  assign w_opcode       = bus.instr_i[6:0];
  assign w_funct3       = bus.instr_i[14:12];
  assign w_funct7_5     = bus.instr_i[30];
  assign w_unused_instr = ^{bus.instr_i[31], bus.instr_i[29:15], bus.instr_i[11:7]};

  Alu_Op_Dec u_alu_op_dec (
    .i_opcode   (w_opcode),
    .i_funct3   (w_funct3),
    .i_funct7_5 (w_funct7_5),
    .o_alu_op   (w_dec_alu_op),
    .o_illegal  (w_dec_illegal)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_wait    <= w_wait_next;
      r_illegal <= w_illegal_next;
      r_timeout <= w_timeout_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_wait_next    = r_wait;
    w_illegal_next = r_illegal;
    w_timeout_next = r_timeout;
    w_wait_tick    = 1'b0;
    w_mem_req      = 1'b0;
    w_mem_we       = 1'b0;
    w_addr_sel     = 1'b0;
    w_ir_we        = 1'b0;
    w_pc_we        = 1'b0;
    w_pc_sel       = 1'b0;
    w_imm_type     = IMM_NONE;
    w_alu_src      = 1'b0;
    w_alu_op       = ALU_ADD;
    w_reg_we       = 1'b0;
    w_wb_sel       = 1'b0;
    w_instret      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start_i) w_state_next = S_FETCH;
      end
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (bus.mem_ack_i) begin
          w_ir_we      = 1'b1;
          w_state_next = S_DECODE;
        end else begin
          w_wait_tick = 1'b1;
        end
      end
      S_DECODE: begin
        w_imm_type = imm_type_of(w_opcode);
        if (w_dec_illegal) begin
          w_illegal_next = 1'b1;
          w_state_next   = S_HALT;
        end else begin
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_imm_type = imm_type_of(w_opcode);
        w_alu_op   = w_dec_alu_op;
        case (w_opcode)
          OP_R: w_state_next = S_WB;
          OP_I: begin
            w_alu_src    = 1'b1;
            w_state_next = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            w_alu_src    = 1'b1;
            w_state_next = S_MEM;
          end
          OP_BRANCH: begin
            // funct3[0] distinguishes bne from beq
            w_pc_we      = 1'b1;
            w_instret    = 1'b1;
            w_pc_sel     = w_funct3[0] ? !bus.zero_i : bus.zero_i;
            w_state_next = S_FETCH;
          end
          default: begin
            w_illegal_next = 1'b1;
            w_state_next   = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        w_imm_type = imm_type_of(w_opcode);
        w_mem_req  = 1'b1;
        w_addr_sel = 1'b1;
        w_mem_we   = (w_opcode == OP_STORE);
        if (bus.mem_ack_i) begin
          if (w_opcode == OP_STORE) begin
            w_pc_we      = 1'b1;
            w_instret    = 1'b1;
            w_state_next = S_FETCH;
          end else begin
            w_state_next = S_WB;
          end
        end else begin
          w_wait_tick = 1'b1;
        end
      end
      S_WB: begin
        w_reg_we     = 1'b1;
        w_wb_sel     = (w_opcode == OP_LOAD);
        w_pc_we      = 1'b1;
        w_instret    = 1'b1;
        w_state_next = S_FETCH;
      end
      S_HALT: w_state_next = S_HALT;
      default: w_state_next = S_IDLE;
    endcase

    // An ack in the final allowed cycle never reaches here, so it wins over the timeout.
    if (w_wait_tick) begin
      if (r_wait == WAIT_LAST) begin
        w_timeout_next = 1'b1;
        w_state_next   = S_HALT;
      end else begin
        w_wait_next = r_wait + 1'b1;
      end
    end
    if (w_state_next != r_state) w_wait_next = '0;
  end

  assign bus.mem_req_o  = w_mem_req;
  assign bus.mem_we_o   = w_mem_we;
  assign bus.addr_sel_o = w_addr_sel;
  assign bus.ir_we_o    = w_ir_we;
  assign bus.pc_we_o    = w_pc_we;
  assign bus.pc_sel_o   = w_pc_sel;
  assign bus.imm_type_o = w_imm_type;
  assign bus.alu_src_o  = w_alu_src;
  assign bus.alu_op_o   = w_alu_op;
  assign bus.reg_we_o   = w_reg_we;
  assign bus.wb_sel_o   = w_wb_sel;
  assign bus.instret_o  = w_instret;
  assign bus.busy_o     = (r_state != S_IDLE) && (r_state != S_HALT);
  assign bus.illegal_o  = r_illegal;
  assign bus.timeout_o  = r_timeout;

endmodule
